// File: rtl/seg7_bcd_writer_pkg.sv
// Shared definitions for the 7-segment BCD writer and the display peripheral.
// The state encoding, digit count, overflow pattern and default base address live here so
// that both ends of the bus agree on them.
package seg7_bcd_writer_pkg;

    // FSM encoding is fixed so that debug taps and the peripheral side read the same values.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StWrDig   = 2'd2,
        StWrDp    = 2'd3
    } seg7_state_e;

    localparam int unsigned SEG7_DIGITS       = 4;
    localparam int unsigned SEG7_BCD_BITS     = 4 * SEG7_DIGITS;
    localparam logic [15:0] SEG7_OVF_PATTERN  = 16'hEEEE;
    localparam logic [31:0] SEG7_DEFAULT_BASE = 32'h0000_0010;

    // Double-dabble correction for one BCD nibble; 4-bit wrap is intended, no carry out.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_bcd_writer_if.sv
// Request channel plus display-bus write port of the BCD writer.
// master: the writer (consumes requests, drives the bus); slave: source/peripheral side.
interface seg7_bcd_writer_if
    import seg7_bcd_writer_pkg::*;
#(
    parameter int unsigned IN_BITS = 16
) ();

    logic                   in_valid;
    logic [IN_BITS-1:0]     in_value;
    logic [SEG7_DIGITS-1:0] in_dp;
    logic                   in_ready;

    logic                   strobe;
    logic                   rw;
    logic [31:0]            addr;
    logic [31:0]            data;
    logic                   busy;

    modport master (
        input  in_valid, in_value, in_dp,
        output in_ready, strobe, rw, addr, data, busy
    );

    modport slave (
        output in_valid, in_value, in_dp,
        input  in_ready, strobe, rw, addr, data, busy
    );

endinterface

// File: rtl/seg7_bcd_writer_bcd_dabble_step.sv
// One combinational double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// {bcd, bin} left by one. Bits shifted out of the top BCD nibble are discarded; the caller
// flags values that are too large separately.
module bcd_dabble_step
    import seg7_bcd_writer_pkg::*;
#(
    parameter int unsigned IN_BITS = 16
) (
    input  logic [SEG7_BCD_BITS-1:0] bcd_i,
    input  logic [IN_BITS-1:0]       bin_i,
    output logic [SEG7_BCD_BITS-1:0] bcd_o,
    output logic [IN_BITS-1:0]       bin_o
);

    logic [SEG7_BCD_BITS-1:0] adj;

    // Per-nibble add-3 correction, independent nibbles.
    always_comb begin
        adj = '0;
        for (int i = 0; i < SEG7_DIGITS; i++) begin
            adj[4*i +: 4] = bcd_add3(bcd_i[4*i +: 4]);
        end
    end

    assign {bcd_o, bin_o} = {adj[SEG7_BCD_BITS-2:0], bin_i, 1'b0};

endmodule

// File: rtl/seg7_bcd_writer.sv
// Accepts a binary value and a decimal-point mask, converts the value to four BCD digits
// with a sequential double-dabble (one iteration per cycle), then issues two single-cycle
// fire-and-forget bus writes: digits to BASE and the DP mask to BASE|1.
module seg7_bcd_writer
    import seg7_bcd_writer_pkg::*;
#(
    parameter logic [31:0] BASE    = SEG7_DEFAULT_BASE,
    parameter int unsigned IN_BITS = 16,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic                clk,
    input  logic                reset,
    seg7_bcd_writer_if.master   bus
);

    localparam int unsigned CntW = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;

    seg7_state_e              state_q, state_d;
    logic [IN_BITS-1:0]       bin_q, bin_d;
    logic [SEG7_BCD_BITS-1:0] bcd_q, bcd_d;
    logic [SEG7_DIGITS-1:0]   dp_q, dp_d;
    logic                     ovf_q, ovf_d;
    logic [CntW-1:0]          cnt_q, cnt_d;

    logic [SEG7_BCD_BITS-1:0] step_bcd;
    logic [IN_BITS-1:0]       step_bin;

    bcd_dabble_step #(
        .IN_BITS (IN_BITS)
    ) u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (step_bcd),
        .bin_o (step_bin)
    );

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: capture on accept, iterate, then walk the two writes.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        dp_d    = dp_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // in_ready is implied by being in StIdle
                if (bus.in_valid) begin
                    bin_d   = bus.in_value;
                    dp_d    = bus.in_dp;
                    ovf_d   = 32'(bus.in_value) > MAX_VAL;
                    bcd_d   = '0;
                    cnt_d   = CntW'(IN_BITS - 1);
                    state_d = StConvert;
                end
            end
            StConvert: begin
                bin_d = step_bin;
                bcd_d = step_bcd;
                if (cnt_q == '0) begin
                    state_d = StWrDig;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWrDig: state_d = StWrDp;
            StWrDp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus and status outputs decoded from state; the bus is all-zero whenever strobe is low.
    always_comb begin
        bus.in_ready = (state_q == StIdle);
        bus.busy     = (state_q != StIdle);
        bus.strobe   = 1'b0;
        bus.rw       = 1'b0;
        bus.addr     = '0;
        bus.data     = '0;
        unique case (state_q)
            StWrDig: begin
                bus.strobe = 1'b1;
                bus.rw     = 1'b1;
                bus.addr   = BASE;
                bus.data   = {16'h0, ovf_q ? SEG7_OVF_PATTERN : bcd_q};
            end
            StWrDp: begin
                bus.strobe = 1'b1;
                bus.rw     = 1'b1;
                bus.addr   = BASE | 32'h1;
                bus.data   = {{(32-SEG7_DIGITS){1'b0}}, dp_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seg7_bcd_writer.sv
// Randomised self-checking bench for seg7_bcd_writer against a decimal-arithmetic model.
module tb_seg7_bcd_writer;

    logic clk = 1'b0;
    logic reset;

    seg7_bcd_writer_if #(.IN_BITS(16)) bus ();

    seg7_bcd_writer #(
        .BASE    (32'h10),
        .IN_BITS (16),
        .MAX_VAL (9999)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-transaction capture, filled by capture().
    int          cap_n;
    int          cap_cyc  [8];
    logic [31:0] cap_addr [8];
    logic [31:0] cap_data [8];
    int          cap_ready;
    int          cap_viol;

    // Reference: four decimal digits, or the overflow pattern above 9999.
    function automatic logic [31:0] exp_digits(input int unsigned v);
        if (v > 9999) return 32'h0000_EEEE;
        return {16'h0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Present a request once the block is ready; returns just after the accepting edge.
    task automatic accept(input logic [15:0] v, input logic [3:0] d);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_dp    = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_value = 16'($urandom);
        bus.in_dp    = 4'($urandom);
    endtask

    // Record strobes, first ready cycle and idle-bus violations over ncyc cycles.
    task automatic capture(input int ncyc);
        cap_n     = 0;
        cap_ready = -1;
        cap_viol  = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (bus.strobe === 1'b1) begin
                if (cap_n < 8) begin
                    cap_cyc[cap_n]  = c;
                    cap_addr[cap_n] = bus.addr;
                    cap_data[cap_n] = bus.data;
                end
                cap_n++;
                if (bus.rw !== 1'b1) cap_viol++;
            end else if (bus.rw !== 1'b0 || bus.addr !== 32'h0 || bus.data !== 32'h0) begin
                cap_viol++;
            end
            if (bus.in_ready === 1'b1 && cap_ready < 0) cap_ready = c;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_value = 16'd1234;
        bus.in_dp    = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.strobe, bus.rw, bus.busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/strobe/rw/busy=%b required 1000",
                     {bus.in_ready, bus.strobe, bus.rw, bus.busy});
        end
        checks++;
        if (bus.addr !== 32'h0 || bus.data !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h required 0/0", bus.addr, bus.data);
        end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        accept(16'd1234, 4'b0100);
        capture(19);
        checks++;
        if (cap_n !== 2) begin
            errors++;
            $display("FAIL basic_count: strobes=%0d required 2", cap_n);
        end
        checks++;
        if (cap_cyc[0] !== 17 || cap_addr[0] !== 32'h10 || cap_data[0] !== 32'h1234) begin
            errors++;
            $display("FAIL basic_dig: cyc=%0d addr=%h data=%h required 17/10/00001234",
                     cap_cyc[0], cap_addr[0], cap_data[0]);
        end
        checks++;
        if (cap_cyc[1] !== 18 || cap_addr[1] !== 32'h11 || cap_data[1] !== 32'h4) begin
            errors++;
            $display("FAIL basic_dp: cyc=%0d addr=%h data=%h required 18/11/00000004",
                     cap_cyc[1], cap_addr[1], cap_data[1]);
        end
        checks++;
        if (cap_ready !== 19) begin
            errors++;
            $display("FAIL basic_ready: first ready cycle=%0d required 19", cap_ready);
        end
        checks++;
        if (cap_viol !== 0) begin
            errors++;
            $display("FAIL basic_idle_bus: violations=%0d required 0", cap_viol);
        end
    endtask

    task automatic test_values();
        logic [15:0] v;
        logic [3:0]  d;
        for (int i = 0; i < 20; i++) begin
            case (i)
                0:       v = 16'd0;
                1:       v = 16'd9999;
                2:       v = 16'd10000;
                3:       v = 16'd65535;
                default: v = (i % 2 == 0) ? 16'($urandom_range(0, 9999))
                                          : 16'($urandom_range(0, 65535));
            endcase
            d = (i == 2 || i == 3) ? 4'hF : 4'($urandom);
            accept(v, d);
            capture(19);
            checks++;
            if (cap_n !== 2 || cap_cyc[0] !== 17 || cap_addr[0] !== 32'h10
                || cap_data[0] !== exp_digits(v)) begin
                errors++;
                $display("FAIL value_dig v=%0d: n=%0d cyc=%0d addr=%h data=%h required 2/17/10/%h",
                         v, cap_n, cap_cyc[0], cap_addr[0], cap_data[0], exp_digits(v));
            end
            checks++;
            if (cap_addr[1] !== 32'h11 || cap_data[1] !== {28'h0, d} || cap_viol !== 0) begin
                errors++;
                $display("FAIL value_dp v=%0d: addr=%h data=%h viol=%0d required 11/%h/0",
                         v, cap_addr[1], cap_data[1], cap_viol, {28'h0, d});
            end
        end
    endtask

    task automatic test_back_to_back();
        int          nacc = 0;
        int          nstb = 0;
        int          acc_cyc [2];
        logic [31:0] stb_data [4];
        bit          hs;
        acc_cyc = '{0, 0};
        stb_data = '{default: 32'h0};
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_value = 16'd42;
        bus.in_dp    = 4'h0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (bus.strobe === 1'b1) begin
                if (nstb < 4) stb_data[nstb] = bus.data;
                nstb++;
            end
            hs = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
            if (hs) begin
                if (nacc < 2) acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk);
            #1;
            if (hs && nacc == 1) bus.in_value = 16'd7;
            if (hs && nacc == 2) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (nacc !== 2 || acc_cyc[1] - acc_cyc[0] !== 19) begin
            errors++;
            $display("FAIL b2b_accepts: accepts=%0d spacing=%0d required 2/19",
                     nacc, acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (nstb !== 4) begin
            errors++;
            $display("FAIL b2b_strobes: strobes=%0d required 4", nstb);
        end
        checks++;
        if (stb_data[0] !== 32'h42 || stb_data[2] !== 32'h7) begin
            errors++;
            $display("FAIL b2b_data: %h then %h required 00000042 then 00000007",
                     stb_data[0], stb_data[2]);
        end
    endtask

    task automatic test_reset_convert();
        accept(16'd4321, 4'h3);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstconv_ready: ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
        end
        capture(20);
        checks++;
        if (cap_n !== 0) begin
            errors++;
            $display("FAIL rstconv_nostrobe: strobes=%0d required 0", cap_n);
        end
        accept(16'd56, 4'h1);
        capture(19);
        checks++;
        if (cap_n !== 2 || cap_cyc[0] !== 17 || cap_data[0] !== 32'h56) begin
            errors++;
            $display("FAIL rstconv_fresh: n=%0d cyc=%0d data=%h required 2/17/00000056",
                     cap_n, cap_cyc[0], cap_data[0]);
        end
    endtask

    task automatic test_reset_wrdig();
        accept(16'd808, 4'h8);
        repeat (17) @(negedge clk);
        checks++;
        if (bus.strobe !== 1'b1 || bus.addr !== 32'h10) begin
            errors++;
            $display("FAIL rstdig_pre: strobe=%b addr=%h required 1/10", bus.strobe, bus.addr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.strobe !== 1'b0 || bus.rw !== 1'b0 || bus.addr !== 32'h0 || bus.data !== 32'h0)
        begin
            errors++;
            $display("FAIL rstdig_bus: strobe=%b rw=%b addr=%h data=%h required all 0",
                     bus.strobe, bus.rw, bus.addr, bus.data);
        end
        capture(20);
        checks++;
        if (cap_n !== 0 || cap_viol !== 0) begin
            errors++;
            $display("FAIL rstdig_nodp: strobes=%0d viol=%0d required 0/0", cap_n, cap_viol);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_dp    = '0;
        reset        = 1'b1;
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_reset_convert();
        test_reset_wrdig();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
